// File: rtl/jt12_pg_enc.sv
// jt12_pg_enc: inverse of the PG block/fnum expansion; normalises a 17-bit phase
// increment into {block, fnum, keycode} by shifting one bit per enabled cycle.
module jt12_pg_enc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] phinc_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] fnum,
  output logic [2:0]  block,
  output logic [4:0]  keycode,
  output logic        exact
);
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t      state;
  logic [17:0] x;
  logic [2:0]  blk;
  logic        sticky;
  assign in_ready = state == IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      x         <= '0;
      blk       <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      fnum      <= '0;
      block     <= '0;
      keycode   <= '0;
      exact     <= 1'b0;
    end else if (clk_en)
      case (state)
        IDLE: if (in_valid) begin
          state  <= NORM;
          x      <= {phinc_in, 1'b0};
          blk    <= '0;
          sticky <= 1'b0;
        end
        NORM: if (|x[17:11]) begin
          x      <= x >> 1;
          blk    <= blk + 3'd1;
          sticky <= sticky | x[0];
        end else begin
          fnum      <= x[10:0];
          block     <= blk;
          keycode   <= {blk, x[10], x[10] ? |x[9:7] : &x[9:7]};
          exact     <= ~sticky;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_jt12_pg_enc.sv
// tb_jt12_pg_enc: directed and random checks of the phase-increment encoder
// against an arithmetic model of the block/fnum law.
module tb_jt12_pg_enc;
  logic        clk = 0, rst_n = 0, clk_en = 1, in_valid = 0, out_ready = 0;
  logic [16:0] phinc_in = '0;
  logic        in_ready, out_valid, exact;
  logic [10:0] fnum;
  logic [2:0]  block;
  logic [4:0]  keycode;
  int checks = 0, errors = 0;
  int exp_f, exp_b, exp_k, exp_e, exp_n;
  logic en_edge, div3 = 0;
  int ph = 0;

  jt12_pg_enc dut (.clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(in_valid),
    .in_ready(in_ready), .phinc_in(phinc_in), .out_valid(out_valid), .out_ready(out_ready),
    .fnum(fnum), .block(block), .keycode(keycode), .exact(exact));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Block = how far the top set bit of 2*phinc sits above bit 10.
  function automatic void model(input int p, output int f, output int b, output int k,
                                output int e, output int n);
    int x = p * 2, h = 0;
    for (int i = 0; i < 18; i++) if ((x >> i) % 2 == 1) h = i;
    b = h > 10 ? h - 10 : 0;
    n = b;
    f = x >> b;
    e = (x % (1 << b)) == 0;
    k = b * 4 + (f >= 1024 ? 2 + ((f % 1024) >= 128 ? 1 : 0) : ((f >> 7) == 7 ? 1 : 0));
  endfunction

  always @(negedge clk)
    if (rst_n && out_valid) begin
      chk("cmp_fnum", fnum, exp_f);
      chk("cmp_block", block, exp_b);
      chk("cmp_keycode", keycode, exp_k);
      chk("cmp_exact", exact, exp_e);
      chk("cmp_in_ready_busy", in_ready, 0);
    end

  task automatic tick();
    @(posedge clk);
    en_edge = clk_en;
    @(negedge clk);
    clk_en = div3 ? (ph == 0) : 1'b1;
    ph = (ph + 1) % 3;
  endtask

  task automatic start(input logic [16:0] p);
    int dummy;
    model(p, exp_f, exp_b, exp_k, exp_e, exp_n);
    phinc_in = p;
    in_valid = 1;
    for (int i = 0; i < 50; i++) begin
      logic r;
      r = in_ready;
      tick();
      if (en_edge && r) break;
    end
    in_valid = 0;
  endtask

  task automatic run_job(input logic [16:0] p, input int hold);
    int edges = 0;
    bit got = 0;
    start(p);
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (en_edge) edges++;
      if (out_valid) got = 1;
    end
    chk("out_valid_timeout", got, 1);
    chk("latency", edges, exp_n + 1);
    for (int i = 0; i < hold; i++) tick();
    out_ready = 1;
    for (int i = 0; i < 20 && out_valid; i++) tick();
    out_ready = 0;
    chk("retire", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fnum", fnum, 0);
    chk("rst_block", block, 0);
    chk("rst_keycode", keycode, 0);
    chk("rst_exact", exact, 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    run_job(17'h003FF, 2);
    chk("c1_fnum", fnum, 11'h7FE);
    chk("c1_block", block, 0);
    chk("c1_keycode", keycode, 5'h03);
    chk("c1_exact", exact, 1);
    run_job(17'h04000, 0);
    chk("c2_fnum", fnum, 11'h400);
    chk("c2_block", block, 5);
    chk("c2_keycode", keycode, 5'h16);
    chk("c2_exact", exact, 1);
    run_job(17'h1FFFF, 0);
    chk("c3_fnum", fnum, 11'h7FF);
    chk("c3_block", block, 7);
    chk("c3_keycode", keycode, 5'h1F);
    chk("c3_exact", exact, 0);
    run_job(17'h00000, 10);
    chk("c4_fnum", fnum, 0);
    chk("c4_block", block, 0);
    chk("c4_keycode", keycode, 0);
    chk("c4_exact", exact, 1);

    // reset in the middle of a 7-shift job
    start(17'h1FFFF);
    tick();
    tick();
    chk("c5_busy", in_ready, 0);
    rst_n = 0;
    #1;
    chk("c5_out_valid", out_valid, 0);
    chk("c5_fnum", fnum, 0);
    chk("c5_block", block, 0);
    chk("c5_keycode", keycode, 0);
    chk("c5_exact", exact, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("c5_in_ready", in_ready, 1);
    begin
      int stale = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (out_valid) stale++;
      end
      chk("c5_no_stale", stale, 0);
    end

    div3 = 1;
    run_job(17'h04000, 3);
    chk("c6_fnum", fnum, 11'h400);
    chk("c6_block", block, 5);
    chk("c6_keycode", keycode, 5'h16);
    div3 = 0;
    @(negedge clk);
    clk_en = 1;

    for (int i = 0; i < 40; i++) begin
      logic [16:0] p;
      p = (i % 2) ? 17'($urandom_range(0, 17'h1FFFF)) : 17'($urandom_range(0, 255) << $urandom_range(0, 9));
      run_job(p, i % 3);
      if (exact) chk("sweep_decode", (int'(fnum) << block) >> 1, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
